// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipelined round-robin arbiter.
package pipeline_pkg;

    localparam int unsigned MAX_REQ     = 16;
    localparam int unsigned MAX_ID_BITS = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Arbiter state, sized for the largest supported requester count.
    typedef struct packed {
        logic [MAX_ID_BITS-1:0] ptr;
        logic                   lock;
        logic [MAX_ID_BITS-1:0] owner;
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin find-first: first set request at or above ptr_i, wrapping.
module rr_priority_select
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_BITS = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_BITS-1:0] ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_BITS-1:0] idx_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl_req;
    logic [2*NUM_REQ-1:0] masked;
    int unsigned          sel;
    int unsigned          wrapped;

    assign dbl_req = {req_i, req_i};

    // Drop lower-copy bits below the pointer; the upper copy supplies the wrapped requests.
    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
            masked[i] = dbl_req[i] & (i >= 32'(ptr_i));
        end
    end

    // Lowest set bit of the masked double-width vector wins.
    always_comb begin
        any_o = 1'b0;
        sel   = 0;
        for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
            if (!any_o && masked[i]) begin
                any_o = 1'b1;
                sel   = i;
            end
        end
    end

    // Fold the double-width position back onto a requester index and one-hot grant.
    always_comb begin
        wrapped = (sel >= NUM_REQ) ? (sel - NUM_REQ) : sel;
        idx_o   = ID_BITS'(wrapped);
        grant_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            grant_o[k] = any_o && (wrapped == k);
        end
    end

endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter with burst lock feeding one registered valid/ready output stage.
module pipeline_rr_arbiter
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned VALUE_BITS = 8,
    parameter int unsigned ID_BITS    = id_width(NUM_REQ)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ*VALUE_BITS-1:0]   i_value,
    input  logic [NUM_REQ-1:0]              i_valid,
    input  logic [NUM_REQ-1:0]              i_last,
    output logic [NUM_REQ-1:0]              o_ready,
    output logic [VALUE_BITS-1:0]           o_value,
    output logic [ID_BITS-1:0]              o_id,
    output logic                            o_last,
    output logic                            o_valid,
    input  logic                            i_ready
);

    localparam logic [ID_BITS-1:0] LastIdx = ID_BITS'(NUM_REQ - 1);

    arb_state_t              state_q, state_d;
    logic [VALUE_BITS-1:0]   value_q;
    logic [ID_BITS-1:0]      id_q;
    logic                    last_q;
    logic                    valid_q;

    logic [ID_BITS-1:0]      ptr;
    logic [ID_BITS-1:0]      owner;
    logic [NUM_REQ-1:0]      rr_grant;
    logic [ID_BITS-1:0]      rr_idx;
    logic                    rr_any;
    logic [ID_BITS-1:0]      win_idx;
    logic                    win_any;
    logic [NUM_REQ-1:0]      win_grant;
    logic                    m_ready;
    logic                    accept;
    logic [VALUE_BITS-1:0]   win_value;
    logic                    win_last;

    assign ptr   = state_q.ptr[ID_BITS-1:0];
    assign owner = state_q.owner[ID_BITS-1:0];

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_select (
        .req_i   (i_valid),
        .ptr_i   (ptr),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    // A held lock overrides round-robin: only the owner may win, and only while valid.
    always_comb begin
        if (state_q.lock) begin
            win_idx   = owner;
            win_any   = i_valid[owner];
            win_grant = '0;
            win_grant[owner] = win_any;
        end else begin
            win_idx   = rr_idx;
            win_any   = rr_any;
            win_grant = rr_grant;
        end
    end

    assign m_ready   = ~valid_q | i_ready;
    assign o_ready   = (reset || !m_ready) ? '0 : win_grant;
    assign accept    = ~reset & m_ready & win_any;
    assign win_value = i_value[32'(win_idx) * VALUE_BITS +: VALUE_BITS];
    assign win_last  = i_last[win_idx];

    // Lock on a non-final beat; release and advance the pointer past the winner on the last beat.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (win_last) begin
                state_d.lock = 1'b0;
                state_d.ptr  = '0;
                state_d.ptr[ID_BITS-1:0] = (win_idx == LastIdx) ? '0 : win_idx + ID_BITS'(1);
            end else begin
                state_d.lock  = 1'b1;
                state_d.owner = '0;
                state_d.owner[ID_BITS-1:0] = win_idx;
            end
        end
    end

    // Arbiter state and output stage; everything holds while the stage is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= '0;
            valid_q <= 1'b0;
            value_q <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (m_ready) begin
                valid_q <= accept;
                if (accept) begin
                    value_q <= win_value;
                    id_q    <= win_idx;
                    last_q  <= win_last;
                end
            end
        end
    end

    assign o_value = value_q;
    assign o_id    = id_q;
    assign o_last  = last_q;
    assign o_valid = valid_q;

    // Upper struct bits stay zero for narrow configurations.
    logic unused_state;
    assign unused_state = ^{state_q.ptr, state_q.owner};

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Directed bench: behavioural arbiter model checked every cycle, plus literal beat-order checks.
module tb_pipeline_rr_arbiter;

    localparam int N  = 4;
    localparam int VB = 8;

    logic            clock;
    logic            reset;
    logic [N*VB-1:0] i_value;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    i_last;
    logic [N-1:0]    o_ready;
    logic [VB-1:0]   o_value;
    logic [1:0]      o_id;
    logic            o_last;
    logic            o_valid;
    logic            i_ready;

    int tests = 0;
    int fails = 0;

    int log_id[$];
    int log_val[$];

    logic [7:0] base;
    logic       vary;

    pipeline_rr_arbiter #(
        .NUM_REQ    (N),
        .VALUE_BITS (VB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .i_value (i_value),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_value (o_value),
        .o_id    (o_id),
        .o_last  (o_last),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int         m_ptr, m_lock, m_owner;
    logic       e_valid, e_last;
    logic [7:0] e_value;
    int         e_id;

    initial begin
        int   win;
        int   k;
        int   exp_rdy;
        logic mready;
        int   n_ptr, n_lock, n_owner;
        logic n_valid, n_last;
        logic [7:0] n_value;
        int   n_id;
        m_ptr = 0; m_lock = 0; m_owner = 0;
        e_valid = 0; e_last = 0; e_value = 0; e_id = 0;
        forever begin
            @(negedge clock);
            win = -1;
            mready = !e_valid || i_ready;
            if (m_lock != 0) begin
                if (i_valid[m_owner]) win = m_owner;
            end else begin
                for (int j = 0; j < N; j++) begin
                    k = (m_ptr + j) % N;
                    if (win < 0 && i_valid[k]) win = k;
                end
            end
            exp_rdy = (!reset && mready && win >= 0) ? (1 << win) : 0;

            chk("o_ready", int'(o_ready), exp_rdy);
            chk("ready_onehot0", int'($onehot0(o_ready)), 1);
            chk("o_valid", int'(o_valid), int'(e_valid));
            chk("o_value", int'(o_value), int'(e_value));
            chk("o_id", int'(o_id), e_id);
            chk("o_last", int'(o_last), int'(e_last));

            if (!reset && o_valid && i_ready) begin
                log_id.push_back(int'(o_id));
                log_val.push_back(int'(o_value));
            end

            n_ptr = m_ptr; n_lock = m_lock; n_owner = m_owner;
            n_valid = e_valid; n_last = e_last; n_value = e_value; n_id = e_id;
            if (reset) begin
                n_ptr = 0; n_lock = 0; n_owner = 0;
                n_valid = 0; n_last = 0; n_value = 0; n_id = 0;
            end else if (mready) begin
                if (win >= 0) begin
                    n_valid = 1;
                    n_value = i_value[win*VB +: VB];
                    n_id    = win;
                    n_last  = i_last[win];
                    if (i_last[win]) begin
                        n_lock = 0;
                        n_ptr  = (win + 1) % N;
                    end else begin
                        n_lock  = 1;
                        n_owner = win;
                    end
                end else begin
                    n_valid = 0;
                end
            end
            @(posedge clock);
            m_ptr = n_ptr; m_lock = n_lock; m_owner = n_owner;
            e_valid = n_valid; e_last = n_last; e_value = n_value; e_id = n_id;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                         input logic rst);
        if (vary) base = base + 8'h10;
        for (int k = 0; k < N; k++) i_value[k*VB +: VB] = base + 8'(k);
        i_valid = v;
        i_last  = l;
        i_ready = rdy;
        reset   = rst;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            drive(v, l, 1'b1, 1'b0);
            tick();
        end
    endtask

    // Compare logged transferred beats with a hand-computed id (and optionally value) list.
    task automatic check_log(input string name, input int n, input int ids[8],
                             input int vals[8], input logic use_vals);
        chk({name, "_count"}, log_id.size(), n);
        for (int i = 0; i < n && i < log_id.size(); i++) begin
            chk({name, "_id"}, log_id[i], ids[i]);
            if (use_vals) chk({name, "_val"}, log_val[i], vals[i]);
        end
        log_id.delete();
        log_val.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int none[8];
        none = '{0, 0, 0, 0, 0, 0, 0, 0};
        base = 8'h10;
        vary = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        tick();
        tick();
        log_id.delete();
        log_val.delete();

        // All four requesting single beats: plain rotation.
        cyc(4'b1111, 4'b1111, 5);
        cyc(4'b0000, 4'b0000, 2);
        check_log("rotate", 5, '{0, 1, 2, 3, 0, 0, 0, 0},
                  '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 0, 0, 0}, 1'b1);

        // Req1 three-beat burst with req0/req2 competing (pointer now at 1).
        vary = 1'b1;
        cyc(4'b0111, 4'b0101, 2);
        cyc(4'b0111, 4'b0111, 3);
        cyc(4'b0000, 4'b0000, 2);
        check_log("burst", 5, '{1, 1, 1, 2, 0, 0, 0, 0}, none, 1'b0);

        // Req2 locks, drops valid for two cycles while req3 waits, then finishes.
        cyc(4'b0100, 4'b0000, 1);
        for (int i = 0; i < 2; i++) begin
            drive(4'b1000, 4'b1000, 1'b1, 1'b0);
            @(negedge clock);
            chk("gap_ready", int'(o_ready), 0);
            tick();
        end
        cyc(4'b1100, 4'b1100, 1);
        cyc(4'b1000, 4'b1000, 1);
        cyc(4'b0000, 4'b0000, 2);
        check_log("gap", 3, '{2, 2, 3, 0, 0, 0, 0, 0}, none, 1'b0);

        // Backpressure for three cycles with a beat held in the output stage.
        cyc(4'b0011, 4'b0011, 1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0011, 4'b0011, 1'b0, 1'b0);
            @(negedge clock);
            chk("bp_ready", int'(o_ready), 0);
            chk("bp_valid", int'(o_valid), 1);
            chk("bp_id", int'(o_id), 0);
            tick();
        end
        cyc(4'b0011, 4'b0011, 1);
        cyc(4'b0000, 4'b0000, 2);
        check_log("bp", 2, '{0, 1, 0, 0, 0, 0, 0, 0}, none, 1'b0);

        // Pointer wrap: req3 alone, then req0 and req3 together.
        cyc(4'b1000, 4'b1000, 1);
        cyc(4'b1001, 4'b1001, 1);
        cyc(4'b0000, 4'b0000, 2);
        check_log("wrap", 2, '{3, 0, 0, 0, 0, 0, 0, 0}, none, 1'b0);

        // Reset in the middle of a req1 burst discards the lock and the held beat.
        cyc(4'b0010, 4'b0000, 1);
        drive(4'b0010, 4'b0000, 1'b1, 1'b1);
        tick();
        drive(4'b0011, 4'b0011, 1'b1, 1'b0);
        @(negedge clock);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_unlock_ready", int'(o_ready), 1);
        tick();
        cyc(4'b0011, 4'b0011, 1);
        cyc(4'b0000, 4'b0000, 2);
        check_log("rst", 2, '{0, 1, 0, 0, 0, 0, 0, 0}, none, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
